cnu_serial: RTL and testbench
=============================

Name: cnu_serial

Overview:
- Serial offset-min-sum check node unit. It sits directly downstream of the variable node unit and upstream of its check-message inputs.
- It consumes the DC extrinsic variable-to-check messages of one check (sum_w-wide two's complement, one per cycle) and saturates them to data_w bits.
- It then emits the DC check-to-variable messages (data_w-wide two's complement, one per cycle) that feed the VNU r inputs, plus the check's parity.

Parameters:
- data_w, 8, width of the emitted check message (two's complement)
- ext_w, 3, guard bits on the incoming message; sum_w = data_w + ext_w
- DC, 6, check-node degree (messages per block), >= 2
- OFFSET, 0, offset subtracted from the emitted magnitude, floored at 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- q_valid  in  1  q_in valid
- q_ready  out  1  block accepts q_in this cycle
- q_in  in  sum_w  variable-to-check message, two's complement
- r_valid  out  1  r_out valid
- r_ready  in  1  consumer accepts r_out
- r_out  out  data_w  check-to-variable message, two's complement
- r_last  out  1  marks the DC-th r_out of a block
- syn  out  1  XOR of all input signs for the current block; meaningful while r_valid=1

Behaviour:
- One clock, rst_n asynchronous active-low. All state is cleared on rst_n low.
- Reset values: state=COLLECT, cnt=0, min1=min2=MAXM, idx1=0, par=0, sign bits=0, r_valid=0, r_last=0, r_out=0, syn=0.
- MAXM = 2^(data_w-1)-1.
- State COLLECT:
  - q_ready=1, r_valid=0.
  - A transfer occurs on q_valid&q_ready.
  - Per transfer, with j=cnt:
    - s = q_in[sum_w-1]; sgn[j] <= s; par <= par^s.
    - m = min(|q_in|, MAXM). The case -2^(sum_w-1) saturates to MAXM.
    - If m < min1: min2<=min1, min1<=m, idx1<=j. Else if m < min2: min2<=m.
    - Comparisons are strict, so on equal minima the first index wins and min2 equals min1.
  - cnt increments. The transfer with cnt=DC-1 moves to EMIT with cnt<=0.
- State EMIT:
  - q_ready=0; q_valid is ignored.
  - r_valid=1 from the first cycle after the last q transfer, so latency is 1 cycle.
  - For j=cnt:
    - mag = (j==idx1 ? min2 : min1).
    - mag' = mag>OFFSET ? mag-OFFSET : 0.
    - sign = par^sgn[j].
    - r_out = sign ? -mag' : mag'.
    - A zero magnitude is always emitted as 0, never negative zero.
  - r_last = (cnt==DC-1). syn = par.
  - On r_valid&r_ready: cnt increments.
  - On the last transfer: return to COLLECT, re-arm min1=min2=MAXM, idx1=0, par=0, cnt=0.
- Backpressure: while r_ready=0, r_out, r_last and syn hold stable and cnt does not advance.
- No overlap between blocks: the next block's first q transfer happens no earlier than the cycle after the last r transfer.
- Throughput: 2*DC cycles per check at full rate.
- rst_n low mid-block (either state) aborts the block. Partial minima and signs are discarded, and the first transfer after release starts a fresh block at index 0.
- Width rules:
  - |q_in| is computed at sum_w+1 bits, or by comparing before negation, so no overflow can occur.
  - The negation of mag' fits in data_w because mag' <= MAXM.
- cnt is clog2(DC) bits and never exceeds DC-1.

Decomposition:
- Package ldpc_pkg holds:
  - data_w/ext_w/sum_w defaults
  - MAXM
  - the state encoding (COLLECT, EMIT)
  - a clog2 helper function
- One sub-module: cnu_sat, combinational. It maps sum_w two's complement to {sign, data_w-1 magnitude} with saturation. It is reusable by other message paths.

Test Plan:
All scenarios use DC=6, data_w=8, ext_w=3, OFFSET=0 unless stated.
1. Basic min-sum: q={5,-3,7,10,-2,4}, r_ready=1 -> r={2,-2,2,2,-3,2}, syn=0, r_last on 6th, first r_valid one cycle after 6th q.
2. Odd parity: q={-1,6,6,6,6,6} -> r={6,-1,-1,-1,-1,-1}, syn=1.
3. Saturation: q={500,-1024,200,300,-600,150} -> r={127,-127,127,127,-127,127}.
4. Tie and offset: q={4,4,9,9,9,9} -> r all 4 with OFFSET=0; with OFFSET=2 -> all 2; with OFFSET=5 -> all 0, no negative zero.
5. Handshake:
   - q_valid toggling 1/0 -> only valid cycles counted.
   - During EMIT, hold r_ready=0 for 3 cycles -> r_out stable, q_ready=0, q_valid pulses ignored.
   - Next block then processes correctly.
6. Reset mid-collect: accept {1,1,1}, pulse rst_n low, then send {5,-3,7,10,-2,4} -> same output as scenario 1.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC message-passing blocks: default widths,
// the largest representable check magnitude and the check-node FSM encoding.
package ldpc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int EXT_W_DEF  = 3;
  localparam int SUM_W_DEF  = DATA_W_DEF + EXT_W_DEF;

  // Largest magnitude a data_w-bit two's complement message may carry
  // symmetrically (the most negative code is never emitted).
  function automatic int maxm_of(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  localparam int MAXM = maxm_of(DATA_W_DEF);

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r = r + 1;
      t = t >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

endpackage

// File: rtl/cnu_serial_if.sv
// Message channels of the serial check node unit.
//
// Handshake: both channels are valid/ready. A transfer happens in a cycle
// where valid and ready are both 1 at the rising clock edge. A producer
// holding valid=1 keeps its data stable until the transfer. The consumer may
// drive ready independently of valid. For the r channel, r_out, r_last and
// syn are stable for as long as r_valid=1 and r_ready=0.
interface cnu_serial_if #(
  parameter int data_w = ldpc_pkg::DATA_W_DEF,
  parameter int ext_w  = ldpc_pkg::EXT_W_DEF
);
  localparam int sum_w = data_w + ext_w;

  logic              q_valid;
  logic              q_ready;
  logic [sum_w-1:0]  q_in;
  logic              r_valid;
  logic              r_ready;
  logic [data_w-1:0] r_out;
  logic              r_last;
  logic              syn;

  // Upstream/downstream side (VNU or testbench).
  modport master (
    output q_valid, q_in, r_ready,
    input  q_ready, r_valid, r_out, r_last, syn
  );

  // Check node unit side.
  modport slave (
    input  q_valid, q_in, r_ready,
    output q_ready, r_valid, r_out, r_last, syn
  );
endinterface

// File: rtl/cnu_sat.sv
// Converts a sum_w-bit two's complement message into sign plus a saturated
// (data_w-1)-bit magnitude. The absolute value is formed one bit wider than
// the input so the most negative input cannot overflow.
module cnu_sat #(
  parameter int data_w = ldpc_pkg::DATA_W_DEF,
  parameter int ext_w  = ldpc_pkg::EXT_W_DEF,
  localparam int sum_w = data_w + ext_w
) (
  input  logic [sum_w-1:0]  x_i,
  output logic              sign_o,
  output logic [data_w-2:0] mag_o
);

  localparam logic [sum_w:0] MAXM_W = {{(ext_w + 2){1'b0}}, {(data_w - 1){1'b1}}};

  logic [sum_w:0] x_ext;
  logic [sum_w:0] abs_w;

  // Sign extend, take absolute value, clamp to the largest symmetric magnitude.
  always_comb begin
    sign_o = x_i[sum_w-1];
    x_ext  = {x_i[sum_w-1], x_i};
    abs_w  = sign_o ? -x_ext : x_ext;
    mag_o  = (abs_w > MAXM_W) ? MAXM_W[data_w-2:0] : abs_w[data_w-2:0];
  end

endmodule

// File: rtl/cnu_serial.sv
// Serial offset-min-sum check node. Collects DC variable-to-check messages,
// tracking the two smallest magnitudes, the position of the smallest and the
// sign parity, then emits DC check-to-variable messages, one per cycle.
// OFFSET is expected to be no larger than the largest magnitude.
module cnu_serial
  import ldpc_pkg::*;
#(
  parameter int data_w = DATA_W_DEF,
  parameter int ext_w  = EXT_W_DEF,
  parameter int DC     = 6,
  parameter int OFFSET = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  cnu_serial_if.slave     bus,
  output ldpc_pkg::state_e state_o
);

  localparam int mag_w = data_w - 1;
  localparam int cnt_w = clog2(DC);
  localparam logic [mag_w-1:0]  MAXM_M = mag_w'(maxm_of(data_w));
  localparam logic [cnt_w-1:0]  LAST   = cnt_w'(DC - 1);
  localparam logic [data_w-1:0] OFF_W  = data_w'(OFFSET);

  state_e            state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic [mag_w-1:0]  min1_q, min1_d;
  logic [mag_w-1:0]  min2_q, min2_d;
  logic [cnt_w-1:0]  idx1_q, idx1_d;
  logic              par_q, par_d;
  logic [DC-1:0]     sgn_q, sgn_d;

  logic              in_sign;
  logic [mag_w-1:0]  in_mag;
  logic [mag_w-1:0]  mag;
  logic [data_w-1:0] mag_ext;
  logic [data_w-1:0] mag_off;
  logic              r_neg;

  cnu_sat #(
    .data_w (data_w),
    .ext_w  (ext_w)
  ) u_sat (
    .x_i    (bus.q_in),
    .sign_o (in_sign),
    .mag_o  (in_mag)
  );

  assign state_o = state_q;

  // Next-state and channel outputs; outputs depend only on registered state,
  // so they hold naturally while the consumer stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx1_d  = idx1_q;
    par_d   = par_q;
    sgn_d   = sgn_q;
    bus.q_ready = 1'b0;
    bus.r_valid = 1'b0;
    bus.r_out   = '0;
    bus.r_last  = 1'b0;
    bus.syn     = 1'b0;
    mag     = min1_q;
    mag_ext = '0;
    mag_off = '0;
    r_neg   = 1'b0;
    case (state_q)
      COLLECT: begin
        bus.q_ready = 1'b1;
        if (bus.q_valid) begin
          sgn_d[cnt_q] = in_sign;
          par_d        = par_q ^ in_sign;
          // Strict compares: on ties the earliest index keeps min1.
          if (in_mag < min1_q) begin
            min2_d = min1_q;
            min1_d = in_mag;
            idx1_d = cnt_q;
          end else if (in_mag < min2_q) begin
            min2_d = in_mag;
          end
          if (cnt_q == LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      EMIT: begin
        bus.r_valid = 1'b1;
        mag     = (cnt_q == idx1_q) ? min2_q : min1_q;
        mag_ext = {1'b0, mag};
        mag_off = (mag_ext > OFF_W) ? (mag_ext - OFF_W) : '0;
        r_neg   = par_q ^ sgn_q[cnt_q];
        // Negating zero yields zero, so no negative zero can appear.
        bus.r_out  = r_neg ? -mag_off : mag_off;
        bus.r_last = (cnt_q == LAST);
        bus.syn    = par_q;
        if (bus.r_ready) begin
          if (cnt_q == LAST) begin
            state_d = COLLECT;
            cnt_d   = '0;
            min1_d  = MAXM_M;
            min2_d  = MAXM_M;
            idx1_d  = '0;
            par_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State registers; reset abandons any partially collected block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      min1_q  <= MAXM_M;
      min2_q  <= MAXM_M;
      idx1_q  <= '0;
      par_q   <= 1'b0;
      sgn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx1_q  <= idx1_d;
      par_q   <= par_d;
      sgn_q   <= sgn_d;
    end
  end

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial. Three instances (OFFSET 0, 2, 5) share the
// same stimulus; OFFSET 2/5 outputs are checked only where expectations are
// queued for them.
module tb_cnu_serial;
  import ldpc_pkg::*;

  localparam int DW  = 8;
  localparam int EW  = 3;
  localparam int SW  = DW + EW;
  localparam int DCN = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          q_valid = 1'b0;
  logic [SW-1:0] q_in = '0;
  logic          r_ready = 1'b0;

  cnu_serial_if #(.data_w(DW), .ext_w(EW)) bus0 ();
  cnu_serial_if #(.data_w(DW), .ext_w(EW)) bus2 ();
  cnu_serial_if #(.data_w(DW), .ext_w(EW)) bus5 ();

  assign bus0.q_valid = q_valid;
  assign bus0.q_in    = q_in;
  assign bus0.r_ready = r_ready;
  assign bus2.q_valid = q_valid;
  assign bus2.q_in    = q_in;
  assign bus2.r_ready = r_ready;
  assign bus5.q_valid = q_valid;
  assign bus5.q_in    = q_in;
  assign bus5.r_ready = r_ready;

  state_e st0, st2, st5;

  cnu_serial #(.data_w(DW), .ext_w(EW), .DC(DCN), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .state_o(st0));
  cnu_serial #(.data_w(DW), .ext_w(EW), .DC(DCN), .OFFSET(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .state_o(st2));
  cnu_serial #(.data_w(DW), .ext_w(EW), .DC(DCN), .OFFSET(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .state_o(st5));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp2_q[$];
  logic [DW-1:0] exp5_q[$];
  logic exp_syn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic push_exp(input int sel, input int a, input int b, input int c,
                          input int d, input int e, input int f);
    int v[6];
    v = '{a, b, c, d, e, f};
    for (int i = 0; i < 6; i++) begin
      if (sel == 0) exp_q.push_back(DW'(v[i]));
      else if (sel == 2) exp2_q.push_back(DW'(v[i]));
      else exp5_q.push_back(DW'(v[i]));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_block(input int a, input int b, input int c, input int d,
                            input int e, input int f, input bit gaps);
    int v[6];
    v = '{a, b, c, d, e, f};
    for (int j = 0; j < DCN; j++) begin
      int w;
      w = 0;
      while (bus0.q_ready !== 1'b1 && w < 50) begin
        @(posedge clk); #1; w++;
      end
      check("q_ready", 32'(bus0.q_ready), 32'd1);
      if (j == DCN - 1) check("r_valid_early", 32'(bus0.r_valid), 32'd0);
      q_valid = 1'b1;
      q_in    = SW'(v[j]);
      @(posedge clk); #1;
      if (gaps && j < DCN - 1) begin
        q_valid = 1'b0;
        q_in    = SW'($urandom_range(0, 2047));
        @(posedge clk); #1;
      end
    end
    q_valid = 1'b0;
    check("r_valid_latency", 32'(bus0.r_valid), 32'd1);
  endtask

  task automatic recv_block(input int stall_at);
    logic [DW-1:0] e;
    for (int j = 0; j < DCN; j++) begin
      int w;
      if (j == stall_at) begin
        r_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          q_valid = (k != 1);
          q_in    = SW'($urandom_range(0, 2047));
          check("stall_r_valid", 32'(bus0.r_valid), 32'd1);
          check("stall_q_ready", 32'(bus0.q_ready), 32'd0);
          check("stall_r_out", 32'($signed(bus0.r_out)), 32'($signed(exp_q[0])));
          @(posedge clk); #1;
        end
        q_valid = 1'b0;
      end
      w = 0;
      while (bus0.r_valid !== 1'b1 && w < 50) begin
        @(posedge clk); #1; w++;
      end
      check("r_valid", 32'(bus0.r_valid), 32'd1);
      r_ready = 1'b1;
      e = exp_q.pop_front();
      check("r_out", 32'($signed(bus0.r_out)), 32'($signed(e)));
      check("r_last", 32'(bus0.r_last), (j == DCN - 1) ? 32'd1 : 32'd0);
      check("syn", 32'(bus0.syn), 32'(exp_syn));
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        check("r_out_off2", 32'($signed(bus2.r_out)), 32'($signed(e)));
      end
      if (exp5_q.size() > 0) begin
        e = exp5_q.pop_front();
        check("r_out_off5", 32'($signed(bus5.r_out)), 32'($signed(e)));
      end
      @(posedge clk); #1;
    end
    r_ready = 1'b0;
    check("r_valid_after", 32'(bus0.r_valid), 32'd0);
    check("q_ready_after", 32'(bus0.q_ready), 32'd1);
    check("state_after", 32'(st0), 32'(COLLECT));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q_ready", 32'(bus0.q_ready), 32'd1);
    check("rst_r_valid", 32'(bus0.r_valid), 32'd0);
    check("rst_r_out", 32'(bus0.r_out), 32'd0);
    check("rst_r_last", 32'(bus0.r_last), 32'd0);
    check("rst_syn", 32'(bus0.syn), 32'd0);
    check("rst_state", 32'(st0), 32'(COLLECT));
    check("rst_r_valid_off2", 32'(bus2.r_valid), 32'd0);
    check("rst_r_valid_off5", 32'(bus5.r_valid), 32'd0);
    check("rst_state_off2", 32'(st2), 32'(COLLECT));
    check("rst_state_off5", 32'(st5), 32'(COLLECT));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic min-sum, even parity.
    push_exp(0, 2, -2, 2, 2, -3, 2);
    exp_syn = 1'b0;
    send_block(5, -3, 7, 10, -2, 4, 1'b0);
    recv_block(-1);

    // Odd parity.
    push_exp(0, 6, -1, -1, -1, -1, -1);
    exp_syn = 1'b1;
    send_block(-1, 6, 6, 6, 6, 6, 1'b0);
    recv_block(-1);

    // Saturation, including the most negative sum_w code.
    push_exp(0, 127, -127, 127, 127, -127, 127);
    exp_syn = 1'b0;
    send_block(500, -1024, 200, 300, -600, 150, 1'b0);
    recv_block(-1);

    // Tie with offsets 0/2/5.
    push_exp(0, 4, 4, 4, 4, 4, 4);
    push_exp(2, 2, 2, 2, 2, 2, 2);
    push_exp(5, 0, 0, 0, 0, 0, 0);
    exp_syn = 1'b0;
    send_block(4, 4, 9, 9, 9, 9, 1'b0);
    recv_block(-1);

    // Tie with odd parity: offset 5 must give plain zero, not negative zero.
    push_exp(0, 4, -4, -4, -4, -4, -4);
    push_exp(2, 2, -2, -2, -2, -2, -2);
    push_exp(5, 0, 0, 0, 0, 0, 0);
    exp_syn = 1'b1;
    send_block(-4, 4, 9, 9, 9, 9, 1'b0);
    recv_block(-1);

    // Gapped q_valid, then a 3-cycle consumer stall with ignored q pulses.
    push_exp(0, 2, -2, 2, 2, -3, 2);
    exp_syn = 1'b0;
    send_block(5, -3, 7, 10, -2, 4, 1'b1);
    recv_block(2);

    // Next block after the stall is unaffected.
    push_exp(0, 6, -1, -1, -1, -1, -1);
    exp_syn = 1'b1;
    send_block(-1, 6, 6, 6, 6, 6, 1'b0);
    recv_block(-1);

    // Reset in the middle of collection discards the partial block.
    for (int j = 0; j < 3; j++) begin
      q_valid = 1'b1;
      q_in    = SW'(1);
      @(posedge clk); #1;
    end
    q_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 32'(st0), 32'(COLLECT));
    check("midrst_r_valid", 32'(bus0.r_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(0, 2, -2, 2, 2, -3, 2);
    exp_syn = 1'b0;
    send_block(5, -3, 7, 10, -2, 4, 1'b0);
    recv_block(-1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
